// File: rtl/i3c_table_mem.sv
// Table memory for the I3C DAT/DCT storage: one single-port RAM shared by
// NumReq requesters under fixed priority (port 0 highest). A zero-fill sweep
// runs after reset and on clear_i. Out-of-range accesses are granted but
// leave the RAM untouched and pulse rerror_o one cycle later.
module i3c_table_mem #(
  parameter int unsigned Depth           = 128,
  parameter int unsigned Width           = 64,
  parameter int unsigned DataBitsPerMask = 32,
  parameter int unsigned NumReq          = 2,
  localparam int unsigned NumMask        = Width / DataBitsPerMask,
  localparam int unsigned Aw             = $clog2(Depth)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  output logic                        busy_o,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           write_i,
  input  logic [NumReq*Aw-1:0]        addr_i,
  input  logic [NumReq*Width-1:0]     wdata_i,
  input  logic [NumReq*NumMask-1:0]   wmask_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           rvalid_o,
  output logic [Width-1:0]            rdata_o,
  output logic [NumReq-1:0]           rerror_o
);

  localparam logic [0:0]    CLEAR   = 1'b1;
  localparam logic [0:0]    IDLE    = 1'b0;
  localparam logic [Aw:0]   DepthV  = (Aw+1)'(Depth);
  localparam logic [Aw-1:0] LastIdx = Aw'(Depth - 1);

  logic [0:0]         state;
  logic [Aw-1:0]      clr_cnt;

  logic               acc_vld_p0;
  logic               acc_write_p0;
  logic [Aw-1:0]      acc_addr_p0;
  logic [Width-1:0]   acc_wdata_p0;
  logic [NumMask-1:0] acc_wmask_p0;
  logic               acc_in_range_p0;

  logic [Width-1:0]   mem [Depth];

  logic [NumReq-1:0]  rvalid_p1;
  logic [NumReq-1:0]  rerror_p1;
  logic [Width-1:0]   rdata_p1;

  assign busy_o = (state == CLEAR);

  // Grant the lowest-index requester while idle and mux its operands
  always_comb begin
    gnt_o        = '0;
    acc_vld_p0   = 1'b0;
    acc_write_p0 = 1'b0;
    acc_addr_p0  = '0;
    acc_wdata_p0 = '0;
    acc_wmask_p0 = '0;
    if (state == IDLE) begin
      for (int p = 0; p < NumReq; p++) begin
        if (req_i[p] && !acc_vld_p0) begin
          gnt_o[p]     = 1'b1;
          acc_vld_p0   = 1'b1;
          acc_write_p0 = write_i[p];
          acc_addr_p0  = addr_i[p*Aw +: Aw];
          acc_wdata_p0 = wdata_i[p*Width +: Width];
          acc_wmask_p0 = wmask_i[p*NumMask +: NumMask];
        end
      end
    end
  end

  // Addresses past Depth exist only when Depth is not a power of two
  assign acc_in_range_p0 = ({1'b0, acc_addr_p0} < DepthV);

  // Sweep FSM: clear_i always restarts the sweep from entry 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (clear_i) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LastIdx) begin
        state   <= IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // RAM write port: sweep zero-fill, else masked write of the granted port
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (acc_vld_p0 && acc_write_p0 && acc_in_range_p0) begin
      for (int g = 0; g < NumMask; g++) begin
        if (acc_wmask_p0[g]) begin
          mem[acc_addr_p0][g*DataBitsPerMask +: DataBitsPerMask] <=
            acc_wdata_p0[g*DataBitsPerMask +: DataBitsPerMask];
        end
      end
    end
  end

  // p0 -> p1: read data, per-port valid and range-error pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_p1 <= '0;
      rerror_p1 <= '0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= acc_write_p0 ? '0 : gnt_o;
      rerror_p1 <= acc_in_range_p0 ? '0 : gnt_o;
      if (acc_vld_p0 && !acc_write_p0) begin
        rdata_p1 <= acc_in_range_p0 ? mem[acc_addr_p0] : '0;
      end
    end
  end

  assign rvalid_o = rvalid_p1;
  assign rerror_o = rerror_p1;
  assign rdata_o  = rdata_p1;

endmodule
